// File: rtl/fetch_ifid.sv
// Instruction fetch + IF/ID latch: owns the PC, drives the icache and holds redirects across an in-flight miss.
// Optional perf counters (fetch_cnt, miss_cnt) are enabled by defining FETCH_PERF_CNT_EN.
module fetch_ifid #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int          WORD_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic [WORD_W-1:0] iload,
    output logic              imemREN,
    output logic [WORD_W-1:0] imemaddr,
    input  logic              stall,
    input  logic              flush,
    input  logic [WORD_W-1:0] redirect_pc,
    input  logic              halt,
    output logic [WORD_W-1:0] instr_out,
    output logic [WORD_W-1:0] npc_out,
    output logic [WORD_W-1:0] pc_out,
    output logic              valid_out,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]       fetch_cnt,
    output logic [31:0]       miss_cnt,
`endif
    output logic              halted
);

    typedef enum logic [1:0] {FETCH, DRAIN, HALTED} state_e;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] rdir_q, rdir_d;
    logic [WORD_W-1:0] instr_q, instr_d;
    logic [WORD_W-1:0] npc_q, npc_d;
    logic [WORD_W-1:0] pco_q, pco_d;
    logic              vld_q, vld_d;
    logic              fetch_ok;
    logic [WORD_W-1:0] rdir_in;
    logic [WORD_W-1:0] pc_plus4;

    assign rdir_in  = {redirect_pc[WORD_W-1:2], 2'b00};
    assign pc_plus4 = pc_q + WORD_W'(4);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rdir_d   = rdir_q;
        instr_d  = instr_q;
        npc_d    = npc_q;
        pco_d    = pco_q;
        vld_d    = vld_q;
        fetch_ok = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (halt || flush) begin
                    instr_d = '0;
                    npc_d   = '0;
                    pco_d   = '0;
                    vld_d   = 1'b0;
                end
                if (halt) begin
                    state_d = HALTED;
                end else if (flush) begin
                    // A miss still in flight must drain before the redirect target is fetched.
                    if (ihit) begin
                        pc_d = rdir_in;
                    end else begin
                        rdir_d  = rdir_in;
                        state_d = DRAIN;
                    end
                end else if (!stall && ihit) begin
                    instr_d  = iload;
                    npc_d    = pc_plus4;
                    pco_d    = pc_q;
                    vld_d    = 1'b1;
                    pc_d     = pc_plus4;
                    fetch_ok = 1'b1;
                end
            end
            DRAIN: begin
                instr_d = '0;
                npc_d   = '0;
                pco_d   = '0;
                vld_d   = 1'b0;
                if (halt) begin
                    state_d = HALTED;
                end else if (flush) begin
                    // Newest redirect wins; if the stale miss lands now, go straight to the new target.
                    if (ihit) begin
                        pc_d    = rdir_in;
                        state_d = FETCH;
                    end else begin
                        rdir_d = rdir_in;
                    end
                end else if (ihit) begin
                    pc_d    = rdir_q;
                    state_d = FETCH;
                end
            end
            default: begin
                instr_d = '0;
                npc_d   = '0;
                pco_d   = '0;
                vld_d   = 1'b0;
                state_d = HALTED;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= FETCH;
            pc_q    <= PC_INIT;
            rdir_q  <= '0;
            instr_q <= '0;
            npc_q   <= '0;
            pco_q   <= '0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            rdir_q  <= rdir_d;
            instr_q <= instr_d;
            npc_q   <= npc_d;
            pco_q   <= pco_d;
            vld_q   <= vld_d;
        end
    end

    assign imemREN   = (state_q != HALTED);
    assign imemaddr  = pc_q;
    assign halted    = (state_q == HALTED);
    assign instr_out = instr_q;
    assign npc_out   = npc_q;
    assign pc_out    = pco_q;
    assign valid_out = vld_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fcnt_q, mcnt_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            fcnt_q <= '0;
            mcnt_q <= '0;
        end else begin
            if (fetch_ok)
                fcnt_q <= fcnt_q + 32'd1;
            if (imemREN && !ihit)
                mcnt_q <= mcnt_q + 32'd1;
        end
    end

    assign fetch_cnt = fcnt_q;
    assign miss_cnt  = mcnt_q;
`else
    logic unused_fetch_ok;
    assign unused_fetch_ok = fetch_ok;
`endif

endmodule

// File: tb/tb_fetch_ifid.sv
// Directed bench for fetch_ifid: sequential fetch, misses, redirects (incl. during a miss), stall, halt, wrap.
module tb_fetch_ifid;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit;
    logic [31:0] iload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        stall;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] instr_out;
    logic [31:0] npc_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] miss_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    fetch_ifid #(.PC_INIT(32'h0), .WORD_W(32)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .iload(iload),
        .imemREN(imemREN), .imemaddr(imemaddr),
        .stall(stall), .flush(flush), .redirect_pc(redirect_pc), .halt(halt),
        .instr_out(instr_out), .npc_out(npc_out), .pc_out(pc_out), .valid_out(valid_out),
`ifdef FETCH_PERF_CNT_EN
        .fetch_cnt(fetch_cnt), .miss_cnt(miss_cnt),
`endif
        .halted(halted)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, "_vld"},   32'(valid_out), 32'h0);
        chk({tag, "_instr"}, instr_out, 32'h0);
        chk({tag, "_pc"},    pc_out, 32'h0);
        chk({tag, "_npc"},   npc_out, 32'h0);
    endtask

    task automatic hit_at(input logic [31:0] a, input string tag);
        chk({tag, "_addr"}, imemaddr, a);
        ihit  = 1'b1;
        iload = word_at(a);
        tick();
        chk({tag, "_pc"},    pc_out, a);
        chk({tag, "_npc"},   npc_out, a + 32'd4);
        chk({tag, "_instr"}, instr_out, word_at(a));
        chk({tag, "_vld"},   32'(valid_out), 32'h1);
    endtask

    task automatic jump_hit(input logic [31:0] tgt);
        flush = 1'b1; redirect_pc = tgt; ihit = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    initial begin
        RST = 1'b1; ihit = 1'b0; iload = '0; stall = 1'b0;
        flush = 1'b0; redirect_pc = '0; halt = 1'b0;
        tick(); tick();
        chk_bubble("rst");
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_ren", 32'(imemREN), 32'h1);
        chk("rst_addr", imemaddr, 32'h0);

        // Sequential hits from 0
        RST = 1'b0;
        for (int i = 0; i < 4; i++) hit_at(32'(4 * i), "seq");

        // Three misses at 0x10, then hit
        ihit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("miss_addr", imemaddr, 32'h10);
            tick();
            chk("miss_hold_pc", pc_out, 32'hC);
            chk("miss_hold_vld", 32'(valid_out), 32'h1);
        end
        hit_at(32'h10, "miss_done");
        for (int i = 0; i < 3; i++) hit_at(32'h14 + 32'(4 * i), "seq2");

        // Flush with hit at 0x20, target low bits cleared
        chk("fl_addr", imemaddr, 32'h20);
        jump_hit(32'h103);
        chk_bubble("fl_hit");
        chk("fl_hit_addr", imemaddr, 32'h100);
        hit_at(32'h100, "fl_tgt");

        // Stall holds PC and IF/ID even with ihit
        jump_hit(32'h4);
        hit_at(32'h4, "pre_stall");
        stall = 1'b1; iload = word_at(32'h8);
        for (int i = 0; i < 2; i++) begin
            chk("stall_addr", imemaddr, 32'h8);
            tick();
            chk("stall_pc", pc_out, 32'h4);
            chk("stall_instr", instr_out, word_at(32'h4));
        end
        stall = 1'b0;
        hit_at(32'h8, "post_stall");
        chk("post_stall_addr", imemaddr, 32'hC);

        // Redirect during a miss, second redirect mid-DRAIN
        jump_hit(32'h40);
        ihit = 1'b0; flush = 1'b1; redirect_pc = 32'h200;
        tick();
        flush = 1'b0;
        chk_bubble("drain0");
        chk("drain0_addr", imemaddr, 32'h40);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("drain_vld", 32'(valid_out), 32'h0);
            chk("drain_addr", imemaddr, 32'h40);
        end
        stall = 1'b1; flush = 1'b1; redirect_pc = 32'h300;
        tick();
        stall = 1'b0; flush = 1'b0;
        chk("drain_fl2_vld", 32'(valid_out), 32'h0);
        ihit = 1'b1; iload = 32'hDEAD_BEEF;
        tick();
        chk_bubble("drain_end");
        chk("drain_end_addr", imemaddr, 32'h300);
        hit_at(32'h300, "drain_tgt");

        // PC wrap
        jump_hit(32'hFFFF_FFFE);
        chk("wrap_addr0", imemaddr, 32'hFFFF_FFFC);
        ihit = 1'b1; iload = word_at(32'hFFFF_FFFC);
        tick();
        chk("wrap_pc", pc_out, 32'hFFFF_FFFC);
        chk("wrap_npc", npc_out, 32'h0);
        chk("wrap_addr", imemaddr, 32'h0);

        // Halt during a miss
        ihit = 1'b0; halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("halt_halted", 32'(halted), 32'h1);
        chk("halt_ren", 32'(imemREN), 32'h0);
        chk_bubble("halt");
        ihit = 1'b1; flush = 1'b1; redirect_pc = 32'h80;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_stay", 32'(halted), 32'h1);
            chk("halt_stay_vld", 32'(valid_out), 32'h0);
        end
        flush = 1'b0;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("unhalt", 32'(halted), 32'h0);
        chk("unhalt_ren", 32'(imemREN), 32'h1);
        chk("unhalt_addr", imemaddr, 32'h0);

        // Reset during DRAIN discards pending redirect
        hit_at(32'h0, "pre_rd");
        hit_at(32'h4, "pre_rd");
        ihit = 1'b0; flush = 1'b1; redirect_pc = 32'h500;
        tick();
        flush = 1'b0; RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("rst_drain_addr", imemaddr, 32'h0);
        chk_bubble("rst_drain");
        hit_at(32'h0, "rst_drain_hit");
        hit_at(32'h4, "rst_drain_hit");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
